// File: rtl/clkmeas_if.sv
// ============================================================================
// clkmeas_if : measured-signal input and measurement results of clkmeas
// Rev 1.0
// ============================================================================
`default_nettype none

interface clkmeas_if #(
    parameter int WIDTH = 16
);
    logic             sig_i;
    logic [WIDTH-1:0] period_o;
    logic [WIDTH-1:0] high_o;
    logic             valid_o;
    logic             timeout_o;

    modport master (
        output sig_i,
        input  period_o,
        input  high_o,
        input  valid_o,
        input  timeout_o
    );

    modport slave (
        input  sig_i,
        output period_o,
        output high_o,
        output valid_o,
        output timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/clkmeas.sv
// ============================================================================
// clkmeas : period / high-time meter for an external square wave, with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module clkmeas #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    clkmeas_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_ARM  = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] s_q;
    logic                   sd_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   ss;
    logic                   rise_d;
    logic                   fall_d;

    state_t                 state_q,   state_d;
    logic [WIDTH-1:0]       cnt_q,     cnt_d;
    logic [WIDTH-1:0]       hreg_q,    hreg_d;
    logic [WIDTH-1:0]       period_q,  period_d;
    logic [WIDTH-1:0]       high_q,    high_d;
    logic                   valid_q,   valid_d;
    logic                   timeout_q, timeout_d;

    assign ss     = s_q[SYNC_STAGES-1];
    assign rise_d = ss & ~sd_q;
    assign fall_d = ~ss & sd_q;

    // Edge pulses are registered so a rise sampled at edge 0 publishes after edge SYNC_STAGES+1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q    <= '0;
            sd_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_q    <= {s_q[SYNC_STAGES-2:0], bus.sig_i};
            sd_q   <= ss;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ARM;
            cnt_q     <= '0;
            hreg_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hreg_q    <= hreg_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreg_d    = hreg_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            ST_ARM: begin
                if (rise_q) begin
                    cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (rise_q) begin
                    period_d  = cnt_q;
                    high_d    = hreg_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                end else if (cnt_q == C_CNT_MAX) begin
                    // Saturation is the loss-of-signal event; the counter never wraps.
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                    state_d   = ST_ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (fall_q) begin
                    hreg_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    assign bus.period_o  = period_q;
    assign bus.high_o    = high_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clkmeas.sv
// ============================================================================
// tb_clkmeas : directed scoreboard bench for clkmeas (SYNC_STAGES 2 and 3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clkmeas;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        have_prev = 1'b0;
    logic [7:0]  prev_period = '0;
    logic [7:0]  prev_high = '0;
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;
    int          lat0;
    int          lat1;

    always #5 clk = ~clk;

    clkmeas_if #(.WIDTH(8)) if0 ();
    clkmeas_if #(.WIDTH(8)) if1 ();

    assign if0.sig_i = sig;
    assign if1.sig_i = sig;

    clkmeas #(.WIDTH(8), .SYNC_STAGES(2)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0)
    );

    clkmeas #(.WIDTH(8), .SYNC_STAGES(3)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One waveform period starting at a negedge; the rise closes the previous period.
    task automatic pulse(input int h, input int l);
        if (have_prev) begin
            q0.push_back({prev_period, prev_high});
            q1.push_back({prev_period, prev_high});
        end
        prev_period = 8'(h + l);
        prev_high   = 8'(h);
        have_prev   = 1'b1;
        sig = 1'b1;
        repeat (h) @(negedge clk);
        sig = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (if0.valid_o) begin
            chk("dut0_valid_width", {31'd0, pv0}, 32'd0);
            chk("dut0_expected_pending", {31'd0, q0.size() != 0}, 32'd1);
            chk("dut0_timeout_on_valid", {31'd0, if0.timeout_o}, 32'd0);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("dut0_period", {24'd0, if0.period_o}, {24'd0, e[15:8]});
                chk("dut0_high",   {24'd0, if0.high_o},   {24'd0, e[7:0]});
            end
        end
        pv0 = if0.valid_o;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (if1.valid_o) begin
            chk("dut1_valid_width", {31'd0, pv1}, 32'd0);
            chk("dut1_expected_pending", {31'd0, q1.size() != 0}, 32'd1);
            chk("dut1_timeout_on_valid", {31'd0, if1.timeout_o}, 32'd0);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1_period", {24'd0, if1.period_o}, {24'd0, e[15:8]});
                chk("dut1_high",   {24'd0, if1.high_o},   {24'd0, e[7:0]});
            end
        end
        pv1 = if1.valid_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_period0",  {24'd0, if0.period_o},  32'd0);
        chk("rst_high0",    {24'd0, if0.high_o},    32'd0);
        chk("rst_valid0",   {31'd0, if0.valid_o},   32'd0);
        chk("rst_timeout0", {31'd0, if0.timeout_o}, 32'd0);
        chk("rst_period1",  {24'd0, if1.period_o},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // high 3 / low 5, then 1-cycle toggling, then 8(4) -> 7(3)
        repeat (4) pulse(3, 5);
        repeat (5) pulse(1, 1);
        repeat (3) pulse(4, 4);
        repeat (3) pulse(3, 4);
        chk("no_timeout0", {31'd0, if0.timeout_o}, 32'd0);
        chk("no_timeout1", {31'd0, if1.timeout_o}, 32'd0);

        // period 10, then held low until both meters time out
        repeat (3) pulse(5, 5);
        for (int i = 0; i < 400 && !(if0.timeout_o && if1.timeout_o); i++) @(negedge clk);
        chk("timeout0",        {31'd0, if0.timeout_o}, 32'd1);
        chk("timeout1",        {31'd0, if1.timeout_o}, 32'd1);
        chk("timeout_period0", {24'd0, if0.period_o},  32'd0);
        chk("timeout_high0",   {24'd0, if0.high_o},    32'd0);
        chk("timeout_period1", {24'd0, if1.period_o},  32'd0);
        chk("timeout_high1",   {24'd0, if1.high_o},    32'd0);
        have_prev = 1'b0;

        pulse(5, 5);
        chk("timeout_held0", {31'd0, if0.timeout_o}, 32'd1);
        chk("timeout_held1", {31'd0, if1.timeout_o}, 32'd1);

        lat0 = -1;
        lat1 = -1;
        fork
            pulse(5, 5);
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1;
                    if (if0.valid_o && lat0 < 0) lat0 = i;
                    if (if1.valid_o && lat1 < 0) lat1 = i;
                end
            end
        join
        chk("latency_ss2", 32'(lat0), 32'd3);
        chk("latency_ss3", 32'(lat1), 32'd4);
        chk("timeout_cleared0", {31'd0, if0.timeout_o}, 32'd0);
        chk("timeout_cleared1", {31'd0, if1.timeout_o}, 32'd0);

        // reset pulsed during the low phase of a period-6 waveform
        pulse(3, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_period0",  {24'd0, if0.period_o},  32'd0);
        chk("midrst_high0",    {24'd0, if0.high_o},    32'd0);
        chk("midrst_valid0",   {31'd0, if0.valid_o},   32'd0);
        chk("midrst_timeout0", {31'd0, if0.timeout_o}, 32'd0);
        chk("midrst_period1",  {24'd0, if1.period_o},  32'd0);
        chk("midrst_valid1",   {31'd0, if1.valid_o},   32'd0);
        q0.delete();
        q1.delete();
        have_prev = 1'b0;
        repeat (3) pulse(3, 3);
        pulse(1, 1);
        repeat (10) @(negedge clk);
        chk("drained0", 32'(q0.size()), 32'd0);
        chk("drained1", 32'(q1.size()), 32'd0);
        chk("hold_period0", {24'd0, if0.period_o}, 32'd6);
        chk("hold_high1",   {24'd0, if1.high_o},   32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
